// File: rtl/e203_exu_alu_divseq.sv
// Sequential radix-2 restoring divider (DIV/DIVU/REM/REMU) that borrows the shared ALU adder and sbf buffers.
// Optional early-out for |dividend| < |divisor| is enabled by defining E203_DIV_EARLY_OUT_EN.
module e203_exu_alu_divseq #(
  parameter int XLEN    = 32,
  parameter int ADDER_W = 35,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [1:0]         i_op,
  input  logic [XLEN-1:0]    i_rs1,
  input  logic [XLEN-1:0]    i_rs2,
  input  logic               i_itag,
  input  logic               flush_req,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [XLEN-1:0]    o_wbck_data,
  output logic               o_itag,
  output logic               muldiv_req_alu,
  output logic [ADDER_W-1:0] muldiv_req_alu_op1,
  output logic [ADDER_W-1:0] muldiv_req_alu_op2,
  output logic               muldiv_req_alu_add,
  output logic               muldiv_req_alu_sub,
  input  logic [ADDER_W-1:0] muldiv_req_alu_res,
  output logic               muldiv_sbf_0_ena,
  output logic [XLEN:0]      muldiv_sbf_0_nxt,
  input  logic [XLEN:0]      muldiv_sbf_0_r,
  output logic               muldiv_sbf_1_ena,
  output logic [XLEN:0]      muldiv_sbf_1_nxt,
  input  logic [XLEN:0]      muldiv_sbf_1_r
);

  typedef enum logic [1:0] {IDLE, EXEC, FIX, RSP} state_e;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic              tag_q;
  logic              sign_q_q;
  logic              sign_r_q;
  logic [XLEN:0]     abs_div_q;
  logic [XLEN-1:0]   wbck_q;

  // Request decode: op[0] selects unsigned, op[1] selects remainder.
  logic              in_signed;
  logic [XLEN:0]     rs1_ext, rs2_ext, abs_rs1, abs_rs2;
  logic              div_zero, div_ovf, special, early, accept;
  logic [XLEN-1:0]   special_res, early_res;

  assign in_signed = ~i_op[0];
  assign rs1_ext   = {in_signed & i_rs1[XLEN-1], i_rs1};
  assign rs2_ext   = {in_signed & i_rs2[XLEN-1], i_rs2};
  assign abs_rs1   = rs1_ext[XLEN] ? -rs1_ext : rs1_ext;
  assign abs_rs2   = rs2_ext[XLEN] ? -rs2_ext : rs2_ext;

  assign div_zero    = (i_rs2 == '0);
  assign div_ovf     = in_signed & (i_rs1 == INT_MIN) & (&i_rs2);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (i_op[1] ? i_rs1 : '1)
                                : (i_op[1] ? '0    : INT_MIN);
  assign early_res   = i_op[1] ? i_rs1 : '0;

`ifdef E203_DIV_EARLY_OUT_EN
  assign early = ~special & (abs_rs1 < abs_rs2);
`else
  assign early = 1'b0;
`endif

  // Flush wins over a same-cycle accept, so nothing is latched on a flushed request.
  assign accept = i_valid & (state_q == IDLE) & ~flush_req;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  logic [XLEN:0]   shifted, rem_nxt;
  logic            qbit;
  logic [XLEN-1:0] fix_raw, fix_res;
  logic            fix_neg;

  assign shifted = {muldiv_sbf_0_r[XLEN-1:0], muldiv_sbf_1_r[XLEN-1]};
  assign qbit    = ~muldiv_req_alu_res[ADDER_W-1];
  assign rem_nxt = qbit ? muldiv_req_alu_res[XLEN:0] : shifted;

  assign fix_raw = op_q[1] ? muldiv_sbf_0_r[XLEN-1:0] : muldiv_sbf_1_r[XLEN-1:0];
  assign fix_neg = op_q[1] ? sign_r_q : sign_q_q;
  assign fix_res = fix_neg ? -fix_raw : fix_raw;

  logic unused_bits;
  assign unused_bits = ^{muldiv_req_alu_res[ADDER_W-2:XLEN+1],
                         muldiv_sbf_0_r[XLEN], muldiv_sbf_1_r[XLEN]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (special || early) ? RSP : EXEC;
      EXEC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = RSP;
      RSP:     if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_req) state_d = IDLE;
  end

  // NOTE: every output gets a default before the case, so no latch can be inferred.
  always_comb begin
    i_ready            = 1'b0;
    o_valid            = 1'b0;
    muldiv_req_alu     = 1'b0;
    muldiv_req_alu_sub = 1'b0;
    muldiv_req_alu_op1 = '0;
    muldiv_req_alu_op2 = '0;
    muldiv_sbf_0_ena   = 1'b0;
    muldiv_sbf_0_nxt   = '0;
    muldiv_sbf_1_ena   = 1'b0;
    muldiv_sbf_1_nxt   = '0;
    unique case (state_q)
      IDLE: begin
        i_ready          = 1'b1;
        muldiv_sbf_0_ena = accept;
        muldiv_sbf_1_ena = accept;
        muldiv_sbf_1_nxt = abs_rs1;
      end
      EXEC: begin
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_sub = 1'b1;
        muldiv_req_alu_op1 = {{(ADDER_W-XLEN-1){shifted[XLEN]}}, shifted};
        muldiv_req_alu_op2 = {{(ADDER_W-XLEN-1){1'b0}}, abs_div_q};
        muldiv_sbf_0_ena   = 1'b1;
        muldiv_sbf_0_nxt   = rem_nxt;
        muldiv_sbf_1_ena   = 1'b1;
        muldiv_sbf_1_nxt   = {muldiv_sbf_1_r[XLEN-1:0], qbit};
      end
      RSP:     o_valid = 1'b1;
      default: ;
    endcase
  end

  assign muldiv_req_alu_add = 1'b0;

  // NOTE: only a handful of control/data flops here, all reset; the bulk operand storage lives in sbf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= 1'b0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      abs_div_q <= '0;
      wbck_q    <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= i_op;
      tag_q     <= i_itag;
      sign_q_q  <= in_signed & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
      sign_r_q  <= in_signed & i_rs1[XLEN-1];
      abs_div_q <= abs_rs2;
      if (special)    wbck_q <= special_res;
      else if (early) wbck_q <= early_res;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (state_q == FIX) begin
      wbck_q <= fix_res;
    end
  end

  assign o_wbck_data = wbck_q;
  assign o_itag      = tag_q;

endmodule

// File: tb/tb_e203_exu_alu_divseq.sv
// Directed self-checking bench for e203_exu_alu_divseq; models the shared 35-bit adder and sbf buffers.
// Latency/adder expectations follow E203_DIV_EARLY_OUT_EN when it is defined for the build.
module tb_e203_exu_alu_divseq;

`ifdef E203_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, i_itag, flush_req;
  logic [1:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic        o_valid, o_ready, o_itag;
  logic [31:0] o_wbck_data;
  logic        muldiv_req_alu, muldiv_req_alu_add, muldiv_req_alu_sub;
  logic [34:0] muldiv_req_alu_op1, muldiv_req_alu_op2, muldiv_req_alu_res;
  logic        muldiv_sbf_0_ena, muldiv_sbf_1_ena;
  logic [32:0] muldiv_sbf_0_nxt, muldiv_sbf_1_nxt, sbf_0_q, sbf_1_q;

  int n_checks = 0;
  int n_fail   = 0;
  int alu_cnt;

  always #5 clk = ~clk;

  e203_exu_alu_divseq dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_valid            (i_valid),
    .i_ready            (i_ready),
    .i_op               (i_op),
    .i_rs1              (i_rs1),
    .i_rs2              (i_rs2),
    .i_itag             (i_itag),
    .flush_req          (flush_req),
    .o_valid            (o_valid),
    .o_ready            (o_ready),
    .o_wbck_data        (o_wbck_data),
    .o_itag             (o_itag),
    .muldiv_req_alu     (muldiv_req_alu),
    .muldiv_req_alu_op1 (muldiv_req_alu_op1),
    .muldiv_req_alu_op2 (muldiv_req_alu_op2),
    .muldiv_req_alu_add (muldiv_req_alu_add),
    .muldiv_req_alu_sub (muldiv_req_alu_sub),
    .muldiv_req_alu_res (muldiv_req_alu_res),
    .muldiv_sbf_0_ena   (muldiv_sbf_0_ena),
    .muldiv_sbf_0_nxt   (muldiv_sbf_0_nxt),
    .muldiv_sbf_0_r     (sbf_0_q),
    .muldiv_sbf_1_ena   (muldiv_sbf_1_ena),
    .muldiv_sbf_1_nxt   (muldiv_sbf_1_nxt),
    .muldiv_sbf_1_r     (sbf_1_q)
  );

  // Environment: the shared ALU adder (subtract) and the two shared buffers.
  assign muldiv_req_alu_res = muldiv_req_alu_op1 - muldiv_req_alu_op2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbf_0_q <= '0;
      sbf_1_q <= '0;
      alu_cnt <= 0;
    end else begin
      if (muldiv_sbf_0_ena) sbf_0_q <= muldiv_sbf_0_nxt;
      if (muldiv_sbf_1_ena) sbf_1_q <= muldiv_sbf_1_nxt;
      if (muldiv_req_alu)   alu_cnt <= alu_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request with o_ready held high; check latency, data, tag and adder usage.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic tag, input logic [31:0] exp,
                        input int exp_lat, input int exp_alu);
    int lat;
    int alu0;
    @(negedge clk);
    check({name, "/i_ready"}, {31'b0, i_ready}, 32'd1);
    alu0    = alu_cnt;
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_itag  = tag;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_valid = 1'b0;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/data"}, o_wbck_data, exp);
    check({name, "/itag"}, {31'b0, o_itag}, {31'b0, tag});
    check({name, "/alu_cycles"}, alu_cnt - alu0, exp_alu);
    @(posedge clk);
    @(negedge clk);
    check({name, "/valid_drop"}, {31'b0, o_valid}, 32'd0);
  endtask

  initial begin : stim
    int  lat;
    bit  saw_valid;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_op      = OP_DIV;
    i_rs1     = '0;
    i_rs2     = '0;
    i_itag    = 1'b0;
    flush_req = 1'b0;
    o_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst/i_ready", {31'b0, i_ready}, 32'd1);
    check("rst/o_valid", {31'b0, o_valid}, 32'd0);
    check("rst/data", o_wbck_data, 32'd0);
    check("rst/req_alu", {31'b0, muldiv_req_alu}, 32'd0);
    check("rst/sbf_ena", {30'b0, muldiv_sbf_0_ena, muldiv_sbf_1_ena}, 32'd0);
    check("rst/alu_add", {31'b0, muldiv_req_alu_add}, 32'd0);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34, 32);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 34, 32);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 34, 32);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34, 32);
    run_op("div_20_m6", OP_DIV, 32'd20, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFD, 34, 32);
    run_op("rem_20_m6", OP_REM, 32'd20, 32'hFFFF_FFFA, 1'b0, 32'd2, 34, 32);
    run_op("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 34, 32);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 34, 32);
    run_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 1'b1, 32'd15, 34, 32);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 0);
    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 1'b0, 32'd0, EARLY ? 1 : 34, EARLY ? 0 : 32);
    run_op("remu_3_10", OP_REMU, 32'd3, 32'd10, 1'b1, 32'd3, EARLY ? 1 : 34, EARLY ? 0 : 32);
    run_op("divu_min_max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,
           EARLY ? 1 : 34, EARLY ? 0 : 32);
    run_op("remu_min_max", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000,
           EARLY ? 1 : 34, EARLY ? 0 : 32);

    // Back-pressure: result and tag must hold while o_ready is low.
    @(negedge clk);
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_op    = OP_DIVU;
    i_rs1   = 32'd100;
    i_rs2   = 32'd7;
    i_itag  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat     = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp/latency", lat, 34);
    for (int k = 0; k < 10; k++) begin
      check("bp/o_valid", {31'b0, o_valid}, 32'd1);
      check("bp/data", o_wbck_data, 32'd14);
      check("bp/itag", {31'b0, o_itag}, 32'd1);
      check("bp/i_ready", {31'b0, i_ready}, 32'd0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp/valid_drop", {31'b0, o_valid}, 32'd0);
    check("bp/i_ready_back", {31'b0, i_ready}, 32'd1);

    // Flush in the middle of EXEC: the op disappears without a result.
    i_valid = 1'b1;
    i_op    = OP_DIVU;
    i_rs1   = 32'd100;
    i_rs2   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush/in_exec", {31'b0, muldiv_req_alu}, 32'd1);
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    check("flush/i_ready", {31'b0, i_ready}, 32'd1);
    check("flush/req_alu", {31'b0, muldiv_req_alu}, 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid = saw_valid | o_valid;
    end
    check("flush/no_valid", {31'b0, saw_valid}, 32'd0);
    run_op("after_flush", OP_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 34, 32);

    // Flush takes priority over a same-cycle accept of a 1-cycle special case.
    @(negedge clk);
    i_valid   = 1'b1;
    i_op      = OP_DIV;
    i_rs1     = 32'd5;
    i_rs2     = 32'd0;
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid   = 1'b0;
    flush_req = 1'b0;
    check("flush_acc/o_valid", {31'b0, o_valid}, 32'd0);
    check("flush_acc/i_ready", {31'b0, i_ready}, 32'd1);

    // Reset mid-operation returns everything to reset values.
    i_valid = 1'b1;
    i_op    = OP_DIV;
    i_rs1   = 32'hFFFF_FFF9;
    i_rs2   = 32'd2;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst/req_alu", {31'b0, muldiv_req_alu}, 32'd0);
    check("midrst/i_ready", {31'b0, i_ready}, 32'd1);
    check("midrst/data", o_wbck_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 34, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e203_exu_alu_divseq.md
Name: e203_exu_alu_divseq

Overview:
- Sequential 32-bit divider for DIV/DIVU/REM/REMU. It is a MULDIV requestor of the shared ALU datapath.
- It has no adder of its own for the iterations. Each trial subtract is issued on the shared 35-bit adder (muldiv_req_alu_*).
- The partial remainder and quotient are held in the shared buffers sbf_0/sbf_1.
- Sits between the EXU issue/dispatch (upstream, valid/ready) and the longpipe write-back (downstream, valid/ready).

Parameters:
- XLEN, 32, operand/result width; only 32 is legal.
- ADDER_W, 35, shared adder width; must match the ALU datapath adder.
- CNT_W, 6, iteration counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  divide request valid
- i_ready  output  1  accept; high only in IDLE
- i_op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- i_rs1  input  32  dividend
- i_rs2  input  32  divisor
- i_itag  input  1  instruction tag, returned unchanged on o_itag
- flush_req  input  1  pipeline flush, cancels any in-flight op
- o_valid  output  1  result valid
- o_ready  input  1  write-back accepts result
- o_wbck_data  output  32  quotient or remainder
- o_itag  output  1  tag of the result
- muldiv_req_alu  output  1  owns the shared adder this cycle
- muldiv_req_alu_op1  output  35  adder operand 1
- muldiv_req_alu_op2  output  35  adder operand 2
- muldiv_req_alu_add  output  1  tied 0
- muldiv_req_alu_sub  output  1  subtract request
- muldiv_req_alu_res  input  35  adder result, same cycle
- muldiv_sbf_0_ena  output  1  sbf_0 write enable (partial remainder)
- muldiv_sbf_0_nxt  output  33  sbf_0 next value
- muldiv_sbf_0_r  input  33  sbf_0 current value
- muldiv_sbf_1_ena  output  1  sbf_1 write enable (dividend/quotient shift register)
- muldiv_sbf_1_nxt  output  33  sbf_1 next value
- muldiv_sbf_1_r  input  33  sbf_1 current value

Behaviour:
Reset:
- State = IDLE; counter = 0; o_valid = 0.
- All muldiv_req_* and sbf enables = 0; o_wbck_data = 0; i_ready = 1.

States: IDLE, EXEC, FIX, RSP.

IDLE:
- A request is accepted on i_valid & i_ready.
- Latched locally: op, tag, sign_q = signed & (rs1[31]^rs2[31]), sign_r = signed & rs1[31].
- |divisor| is latched locally (33-bit, via local negator).
- sbf_1 <= {1'b0, |dividend|}; sbf_0 <= 0; counter = 0.
- Special cases go straight to RSP; no adder use; result registered locally:
  - rs2 == 0 -> quotient = 0xFFFFFFFF, remainder = rs1.
  - signed, rs1 = 0x80000000, rs2 = 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
- Otherwise -> EXEC.

EXEC (exactly 32 cycles), each cycle:
- muldiv_req_alu = 1, muldiv_req_alu_sub = 1.
- op1 = sign-extended {sbf_0[31:0], sbf_1[31]}; op2 = {2'b0, |divisor|}.
- If res[34] == 0: sbf_0 <= res[32:0], qbit = 1; else sbf_0 <= shifted value, qbit = 0.
- sbf_1 <= {sbf_1[31:0], qbit}.
- Counter increments; at counter == 31 -> FIX.

FIX (1 cycle):
- Quotient = sbf_1[31:0], remainder = sbf_0[31:0].
- Negate the selected result locally if sign_q (DIV) or sign_r (REM).
- Register into o_wbck_data. -> RSP.

RSP:
- o_valid = 1; o_wbck_data and o_itag are stable until o_valid & o_ready.
- On handshake -> IDLE. i_ready stays 0 until IDLE; no back-to-back accept in the handshake cycle.

Latency (accept to o_valid): normal 34 cycles; special case 1 cycle.

flush_req:
- Any state -> IDLE at the next edge; o_valid drops; no result issued.
- flush_req has priority over a same-cycle accept or handshake.

Shared-datapath rules:
- muldiv_req_alu is 0 outside EXEC.
- sbf enables are asserted only in the IDLE accept cycle and in EXEC.

Reset asserted mid-operation: immediate return to the reset values; the op is lost.

Optional Feature:
Macro E203_DIV_EARLY_OUT_EN.
- Defined: a local unsigned compare in IDLE. If |dividend| < |divisor| (and not a special case) -> RSP in 1 cycle with quotient = 0, remainder = rs1. EXEC is skipped and the shared adder is not requested.
- Undefined: no compare; such cases take the full 34 cycles. Results are bit-identical either way.

Test Plan:
- DIVU 100/7, o_ready=1 -> o_valid at cycle 34, data 14; REMU same operands -> 2.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); muldiv_req_alu high exactly 32 cycles.
- DIV 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5; muldiv_req_alu never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; 1-cycle latency.
- Back-pressure: o_ready=0 for 10 cycles in RSP -> o_valid/o_wbck_data/o_itag held; i_ready=0 throughout. flush_req in EXEC cycle 10 -> IDLE next cycle, no o_valid, next request correct.
- E203_DIV_EARLY_OUT_EN defined, DIVU 3/10 -> quotient 0, REMU -> 3, 1-cycle latency; undefined -> same data at 34 cycles.
